// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encodings and frame constants for uart_rx
// Purpose: one place for the receiver FSM encoding and the frame shape.
// Contents: state_t (IDLE/START/DATA/PARITY/STOP), DATA_BITS.
// Optional feature macro: UART_RX_PARITY_EN (PARITY state only reached when defined).
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte output handshake between uart_rx and its consumer
// Purpose: bundles the received-byte register, its valid/ready handshake and error pulses.
// Signals: data[7:0], valid, ready, frame_err, overrun, parity_err (UART_RX_PARITY_EN only).
// Modports: master = receiver side (drives data/valid/pulses, reads ready),
//           slave  = consumer side (reads data/valid/pulses, drives ready).
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output data, valid, frame_err, overrun, parity_err, input ready);
  modport slave  (input data, valid, frame_err, overrun, parity_err, output ready);
`else
  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);
`endif
endinterface

// File: rtl/PulseGen.sv
// rtl/PulseGen.sv - periodic one-clock pulse at OUT_FREQ derived from CLK_FREQ
// Purpose: divides the system clock into a single-cycle enable pulse (rounded divider).
// Ports: clk  in  system clock
//        rst  in  asynchronous active-high reset
//        pulse out 1-clk pulse every round(CLK_FREQ/OUT_FREQ) clocks
module PulseGen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int OUT_FREQ = 153_600
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  localparam int DIV = (CLK_FREQ + OUT_FREQ / 2) / OUT_FREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      pulse <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling serial receiver (8N1, or 8E1 with UART_RX_PARITY_EN)
// Purpose: synchronises the rx pin, finds start bits, samples each bit at mid-bit and
//   presents every good byte on a valid/ready output register with frame/overrun pulses.
// Ports: clk  in   system clock
//        rst  in   asynchronous active-high reset
//        rx   in   serial line, idle high, asynchronous to clk
//        bus  uart_rx_if.master: data, valid, ready, frame_err, overrun, parity_err
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data bits).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam logic [TC_W-1:0] MID_START = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] FULL_BIT  = TC_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

  logic tick;

  PulseGen #(
    .CLK_FREQ(CLK_FREQ),
    .OUT_FREQ(BAUD * OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .pulse(tick)
  );

  // Two-flop synchroniser; resets to the idle (high) level.
  logic rx_meta, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  state_t          state;
  logic [TC_W-1:0] tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            armed;
  logic            deliver;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            parity_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      armed        <= 1'b0;
      deliver      <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      deliver      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // Output register: shift_reg is stable here because the FSM is back in IDLE.
      if (deliver) begin
        if (!valid_q || bus.ready) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err_q <= ^shift_reg ^ par_bit;
`endif
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_IDLE: begin
            // Arming on a tick (not every clk) keeps the synchroniser's reset-value
            // ones from arming the receiver while the pin is actually low.
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == MID_START) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt == FULL_BIT) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == FULL_BIT) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            // Return to IDLE at mid-stop so the next start edge gets half a bit of slack.
            if (tick_cnt == FULL_BIT) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              if (rx_s) begin
                deliver <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
                armed       <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BAUD       = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int CLK_FREQ   = BAUD * OVERSAMPLE * 4;
  localparam int BIT_CLKS   = OVERSAMPLE * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus();

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   fe_cnt   = 0;
  int   ov_cnt   = 0;
  int   pe_cnt   = 0;
  int   rise_cnt = 0;
  int   hi_cnt   = 0;
  logic valid_d  = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err === 1'b1) pe_cnt++;
`endif
    if (bus.valid === 1'b1 && valid_d !== 1'b1) rise_cnt++;
    if (bus.valid === 1'b1) hi_cnt++;
    valid_d = bus.valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  // Leaves rx at the stop-bit level so a break can follow directly.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rdy;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_rise;
    int         exp_fe;
    int         exp_ov;
    int         exp_hi;   // -1: not checked
  } vec_t;

  vec_t vecs[8];

  int fe0, ov0, pe0, rise0, hi0;

  task automatic snap();
    fe0   = fe_cnt;
    ov0   = ov_cnt;
    pe0   = pe_cnt;
    rise0 = rise_cnt;
    hi0   = hi_cnt;
  endtask

  initial begin
    //          d      stop  rdy   data   vld   rise fe ov hi
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1,   0, 0, 1};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1,   0, 0, -1};
    vecs[2] = '{8'hC3, 1'b1, 1'b0, 8'h3C, 1'b1, 0,   0, 1, -1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1,   0, 0, -1};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 0,   1, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1,   0, 0, 1};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1,   0, 0, -1};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 8'h80, 1'b1, 0,   0, 1, -1};

    bus.ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", bus.data, 8'h00);
    check("reset valid", bus.valid, 1'b0);
    check("reset frame_err", bus.frame_err, 1'b0);
    check("reset overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    idle_bits(2);

    // Table of single frames
    for (int i = 0; i < 8; i++) begin
      snap();
      bus.ready = vecs[i].rdy;
      send_frame(vecs[i].d, vecs[i].stop);
      idle_bits(2);
      check($sformatf("v%0d data", i), bus.data, vecs[i].exp_data);
      check($sformatf("v%0d valid", i), bus.valid, vecs[i].exp_valid);
      check($sformatf("v%0d valid rises", i), rise_cnt - rise0, vecs[i].exp_rise);
      check($sformatf("v%0d frame_err cycles", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("v%0d overrun cycles", i), ov_cnt - ov0, vecs[i].exp_ov);
`ifdef UART_RX_PARITY_EN
      check($sformatf("v%0d parity_err cycles", i), pe_cnt - pe0, 0);
`endif
      if (vecs[i].exp_hi >= 0)
        check($sformatf("v%0d valid high cycles", i), hi_cnt - hi0, vecs[i].exp_hi);
    end

    // Consume the held byte: valid drops, data stays
    bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("consume valid", bus.valid, 1'b0);
    check("consume data", bus.data, 8'h80);

    // Short low glitch (4 sample ticks) is not a start bit
    snap();
    rx = 1'b0;
    repeat (16) @(posedge clk);
    idle_bits(10);
    check("glitch valid rises", rise_cnt - rise0, 0);
    check("glitch frame_err", fe_cnt - fe0, 0);
    check("glitch overrun", ov_cnt - ov0, 0);
    check("glitch valid", bus.valid, 1'b0);

    // Bad stop bit followed by a 20-bit break: one frame error, no restart until high
    snap();
    send_frame(8'h55, 1'b0);
    repeat (20 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    check("break frame_err", fe_cnt - fe0, 1);
    check("break valid rises", rise_cnt - rise0, 0);
    check("break valid", bus.valid, 1'b0);
    idle_bits(2);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check("after break data", bus.data, 8'h5A);
    check("after break rises", rise_cnt - rise0, 1);
    check("after break frame_err", fe_cnt - fe0, 1);

    // Reset in the middle of 0x81 while rx is low
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset data", bus.data, 8'h00);
    check("midreset valid", bus.valid, 1'b0);
    rst = 1'b0;
    repeat (BIT_CLKS - 23) @(posedge clk);
    for (int i = 3; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(2);
    check("post reset rises", rise_cnt - rise0, 0);
    check("post reset frame_err", fe_cnt - fe0, 0);
    check("post reset overrun", ov_cnt - ov0, 0);
    send_frame(8'h7E, 1'b1);
    idle_bits(2);
    check("post reset 7E data", bus.data, 8'h7E);
    check("post reset 7E rises", rise_cnt - rise0, 1);

`ifdef UART_RX_PARITY_EN
    // Odd-weight byte with parity bit 0 violates even parity
    snap();
    send_frame_par(8'h01, 1'b0);
    idle_bits(2);
    check("parity data", bus.data, 8'h01);
    check("parity rises", rise_cnt - rise0, 1);
    check("parity_err cycles", pe_cnt - pe0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
